core_v2: RTL

CORE_V2 -- requirements
Module: core_v2

---
 rtl/core_v2.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/core_v2.sv
// core_v2: multi-cycle RV32I-subset core, one FETCH and one EXEC cycle per instruction.
// Define CORE_V2_BRANCH_EN to add BEQ/BNE/BLT/BGE/BLTU/BGEU and JAL.
module core_v2 #(
   parameter int                NREGS    = 32,
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                CNT_W    = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   input  logic [ADDR_W-1:0] last_pc,
   output logic              halted,
   output logic              illegal,
   output logic              retire,
   output logic [CNT_W-1:0]  instret
);

   localparam int         RI_W    = $clog2(NREGS);
   localparam logic [5:0] NREGS_L = 6'(NREGS);
   localparam logic [6:0] OPC_OPIMM = 7'h13;
   localparam logic [6:0] OPC_OP    = 7'h33;
   localparam logic [6:0] OPC_LUI   = 7'h37;
   localparam logic [6:0] OPC_SYS   = 7'h73;
`ifdef CORE_V2_BRANCH_EN
   localparam logic [6:0] OPC_BR    = 7'h63;
   localparam logic [6:0] OPC_JAL   = 7'h6F;
`endif

   typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic [31:0]       ir;
   logic [31:0]       rf [NREGS];

   logic [6:0]  opc, f7;
   logic [2:0]  f3;
   logic [4:0]  rd, rs1, rs2;
   logic        rd_ok, rs1_ok, rs2_ok;
   logic [31:0] rs1_v, rs2_v, imm_i, alu_b, alu_res, wb_val;
   logic        legal, wr_en, brk;
   logic [ADDR_W-1:0] pc_inc, pc_nxt;

   assign opc = ir[6:0];
   assign rd  = ir[11:7];
   assign f3  = ir[14:12];
   assign rs1 = ir[19:15];
   assign rs2 = ir[24:20];
   assign f7  = ir[31:25];

   // Index checks only matter for RV32E; with 32 registers they are always true.
   assign rd_ok  = {1'b0, rd}  < NREGS_L;
   assign rs1_ok = {1'b0, rs1} < NREGS_L;
   assign rs2_ok = {1'b0, rs2} < NREGS_L;

   assign rs1_v = (rs1 == 5'd0 || !rs1_ok) ? '0 : rf[rs1[RI_W-1:0]];
   assign rs2_v = (rs2 == 5'd0 || !rs2_ok) ? '0 : rf[rs2[RI_W-1:0]];
   assign imm_i = {{20{ir[31]}}, ir[31:20]};
   assign alu_b = (opc == OPC_OP) ? rs2_v : imm_i;
   assign pc_inc = pc + ADDR_W'(1);

   assign imem_addr = pc;
   // Legality is known only once IR is decoded, so retire is a decode of EXEC.
   assign retire = (state == EXEC) && legal;

   always_comb begin
      alu_res = '0;
      case (f3)
         3'b000: alu_res = (opc == OPC_OP && f7[5]) ? rs1_v - alu_b : rs1_v + alu_b;
         3'b001: alu_res = rs1_v << alu_b[4:0];
         3'b010: alu_res = {31'b0, $signed(rs1_v) < $signed(alu_b)};
         3'b011: alu_res = {31'b0, rs1_v < alu_b};
         3'b100: alu_res = rs1_v ^ alu_b;
         3'b101: alu_res = f7[5] ? 32'($signed(rs1_v) >>> alu_b[4:0]) : rs1_v >> alu_b[4:0];
         3'b110: alu_res = rs1_v | alu_b;
         3'b111: alu_res = rs1_v & alu_b;
         default: alu_res = '0;
      endcase
   end

`ifdef CORE_V2_BRANCH_EN
   logic signed [31:0] imm_b, imm_j;
   logic [ADDR_W-1:0]  br_tgt, jal_tgt;
   logic               br_take;

   // Targets are word addresses, so the byte offset is scaled down by 4.
   assign imm_b   = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
   assign imm_j   = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
   assign br_tgt  = pc + ADDR_W'(imm_b >>> 2);
   assign jal_tgt = pc + ADDR_W'(imm_j >>> 2);

   always_comb begin
      br_take = 1'b0;
      case (f3)
         3'b000: br_take = rs1_v == rs2_v;
         3'b001: br_take = rs1_v != rs2_v;
         3'b100: br_take = $signed(rs1_v) <  $signed(rs2_v);
         3'b101: br_take = $signed(rs1_v) >= $signed(rs2_v);
         3'b110: br_take = rs1_v <  rs2_v;
         3'b111: br_take = rs1_v >= rs2_v;
         default: br_take = 1'b0;
      endcase
   end
`endif

   always_comb begin
      legal  = 1'b0;
      wr_en  = 1'b0;
      brk    = 1'b0;
      wb_val = alu_res;
      pc_nxt = pc_inc;
      case (opc)
         OPC_OPIMM: begin
            wr_en = 1'b1;
            legal = rd_ok && rs1_ok &&
                    ((f3 == 3'b001) ? (f7 == 7'h00) :
                     (f3 == 3'b101) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1);
         end
         OPC_OP: begin
            wr_en = 1'b1;
            legal = rd_ok && rs1_ok && rs2_ok &&
                    (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
         end
         OPC_LUI: begin
            wr_en  = 1'b1;
            legal  = rd_ok;
            wb_val = {ir[31:12], 12'b0};
         end
         OPC_SYS: begin
            legal = (ir == 32'h0010_0073);
            brk   = legal;
         end
`ifdef CORE_V2_BRANCH_EN
         OPC_BR: begin
            legal = rs1_ok && rs2_ok && (f3[2:1] != 2'b01);
            if (br_take) pc_nxt = br_tgt;
         end
         OPC_JAL: begin
            wr_en  = 1'b1;
            legal  = rd_ok;
            wb_val = 32'(pc_inc);
            pc_nxt = jal_tgt;
         end
`endif
         default: legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= FETCH;
         pc       <= RESET_PC;
         ir       <= '0;
         instret  <= '0;
         halted   <= 1'b0;
         illegal  <= 1'b0;
         imem_req <= 1'b1;
         for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      end else begin
         case (state)
            FETCH: if (imem_ack) begin
               ir       <= imem_rdata;
               imem_req <= 1'b0;
               state    <= EXEC;
            end
            EXEC: if (!legal) begin
               state   <= HALT;
               halted  <= 1'b1;
               illegal <= 1'b1;
            end else begin
               if (wr_en && rd != 5'd0) rf[rd[RI_W-1:0]] <= wb_val;
               instret <= instret + CNT_W'(1);
               // The last-pc check uses the executed pc, not the branch target.
               if (brk || pc == last_pc) begin
                  state  <= HALT;
                  halted <= 1'b1;
               end else begin
                  pc       <= pc_nxt;
                  imem_req <= 1'b1;
                  state    <= FETCH;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
